// File: rtl/pc_fetch_unit.sv
// PC generator and instruction-fetch requester at the head of IF.
// Optional build macro: MISALIGN_TRAP_EN (misaligned redirect targets trap to TRAP_VEC).
`timescale 1ns/1ps
module pc_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] TRAP_VEC = ADDR_W'(32'h0000_0100)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_stall,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    input  logic              i_ack,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_four,
    output logic              o_req,
    output logic              o_drop,
    output logic              o_flush,
    output logic              o_misalign
);

    typedef enum logic [1:0] {BOOT, FETCH, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pend_q, pend_d, pc_four, target;
    logic              hold_q, hold_d, req, flush, drop, mis_target;
    logic              unused_bits;

    assign unused_bits = &{1'b0, i_redirect_pc[1:0]};

`ifdef MISALIGN_TRAP_EN
    assign mis_target = i_redirect_pc[1];
    assign target     = mis_target ? TRAP_VEC : {i_redirect_pc[ADDR_W-1:2], 2'b00};
`else
    assign mis_target = 1'b0;
    assign target     = {i_redirect_pc[ADDR_W-1:2], 2'b00};
`endif

    assign pc_four = pc_q + ADDR_W'(4);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        hold_d  = hold_q;
        req     = 1'b0;
        flush   = 1'b0;
        drop    = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = FETCH;
                if (i_redirect) begin
                    flush = 1'b1;
                    pc_d  = target;
                end
            end
            FETCH: begin
                // An outstanding request is never retracted by a stall.
                req = hold_q | ~i_stall;
                if (i_redirect) begin
                    flush = 1'b1;
                    if (req && i_ack) begin
                        drop   = 1'b1;
                        pc_d   = target;
                        hold_d = 1'b0;
                    end else if (req) begin
                        pend_d  = target;
                        hold_d  = 1'b1;
                        state_d = DRAIN;
                    end else begin
                        pc_d = target;
                    end
                end else if (req && i_ack) begin
                    pc_d   = pc_four;
                    hold_d = 1'b0;
                end else if (req) begin
                    hold_d = 1'b1;
                end
            end
            DRAIN: begin
                req = 1'b1;
                if (i_redirect) begin
                    flush  = 1'b1;
                    pend_d = target;
                end
                if (i_ack) begin
                    drop    = 1'b1;
                    pc_d    = i_redirect ? target : pend_q;
                    hold_d  = 1'b0;
                    state_d = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            hold_q  <= hold_d;
        end
    end

    // Pulses are masked during reset so a live redirect cannot leak through BOOT.
    assign o_pc       = pc_q;
    assign o_pc_four  = pc_four;
    assign o_req      = req;
    assign o_flush    = flush & i_rst_n;
    assign o_drop     = drop & i_rst_n;
    assign o_misalign = flush & mis_target & i_rst_n;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: per-cycle expectations queued at drive time, checked at negedge.
`timescale 1ns/1ps
module tb_pc_fetch_unit;

    logic        i_clk = 1'b0;
    logic        i_rst_n, i_stall, i_redirect, i_ack;
    logic [31:0] i_redirect_pc;
    logic [31:0] o_pc, o_pc_four, w_pc, w_pc_four;
    logic        o_req, o_drop, o_flush, o_misalign;
    logic        w_req, w_drop, w_flush, w_misalign;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] pc;
        logic        req, flush, drop, mis, wchk;
        logic [31:0] wpc;
    } exp_t;

    exp_t sb[$];

`ifdef MISALIGN_TRAP_EN
    localparam logic EXP_MIS = 1'b1;
`else
    localparam logic EXP_MIS = 1'b0;
`endif

    always #5 i_clk = ~i_clk;

    pc_fetch_unit u_dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall), .i_redirect(i_redirect),
        .i_redirect_pc(i_redirect_pc), .i_ack(i_ack), .o_pc(o_pc), .o_pc_four(o_pc_four),
        .o_req(o_req), .o_drop(o_drop), .o_flush(o_flush), .o_misalign(o_misalign)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall), .i_redirect(i_redirect),
        .i_redirect_pc(i_redirect_pc), .i_ack(i_ack), .o_pc(w_pc), .o_pc_four(w_pc_four),
        .o_req(w_req), .o_drop(w_drop), .o_flush(w_flush), .o_misalign(w_misalign)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and queue what the DUT must show during it.
    task automatic step(input logic stall, input logic redir, input logic [31:0] rpc,
                        input logic ack, input logic [31:0] pc, input logic req,
                        input logic flush, input logic drop, input logic mis,
                        input logic wchk, input logic [31:0] wpc);
        exp_t e;
        i_stall = stall; i_redirect = redir; i_redirect_pc = rpc; i_ack = ack;
        e.pc = pc; e.req = req; e.flush = flush; e.drop = drop; e.mis = mis;
        e.wchk = wchk; e.wpc = wpc;
        sb.push_back(e);
        @(posedge i_clk); #1;
    endtask

    initial begin
        forever begin
            @(negedge i_clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("pc",       o_pc,       e.pc);
                chk("pc_four",  o_pc_four,  e.pc + 32'd4);
                chk("req",      32'(o_req),      32'(e.req));
                chk("flush",    32'(o_flush),    32'(e.flush));
                chk("drop",     32'(o_drop),     32'(e.drop));
                chk("misalign", 32'(o_misalign), 32'(e.mis));
                if (e.wchk) begin
                    chk("wrap_pc",      w_pc,      e.wpc);
                    chk("wrap_pc_four", w_pc_four, e.wpc + 32'd4);
                end
            end
        end
    end

    initial begin
        i_rst_n = 1'b0; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0; i_ack = 1'b0;
        @(posedge i_clk); @(posedge i_clk); #1;
        chk("rst_pc",    o_pc, 32'h0);
        chk("rst_req",   32'(o_req), 32'h0);
        chk("rst_flush", 32'(o_flush), 32'h0);
        chk("rst_wpc",   w_pc, 32'hFFFF_FFF8);
        i_rst_n = 1'b1;
        //    stall redir rpc            ack  pc             req flush drop mis  wchk wpc
        step(0, 0, 32'h0,         1, 32'h0,         0, 0, 0, 0,       1, 32'hFFFF_FFF8); // BOOT
        step(0, 0, 32'h0,         1, 32'h0,         1, 0, 0, 0,       1, 32'hFFFF_FFF8);
        step(0, 0, 32'h0,         1, 32'h4,         1, 0, 0, 0,       1, 32'hFFFF_FFFC);
        step(0, 0, 32'h0,         1, 32'h8,         1, 0, 0, 0,       1, 32'h0);
        step(0, 0, 32'h0,         1, 32'hC,         1, 0, 0, 0,       1, 32'h4);
        // request held across a stall
        step(0, 0, 32'h0,         0, 32'h10,        1, 0, 0, 0,       0, 32'h0);
        step(1, 0, 32'h0,         0, 32'h10,        1, 0, 0, 0,       0, 32'h0);
        step(1, 0, 32'h0,         0, 32'h10,        1, 0, 0, 0,       0, 32'h0);
        step(1, 0, 32'h0,         0, 32'h10,        1, 0, 0, 0,       0, 32'h0);
        step(0, 0, 32'h0,         1, 32'h10,        1, 0, 0, 0,       0, 32'h0);
        // redirect with outstanding request -> DRAIN
        step(0, 1, 32'h200,       0, 32'h14,        1, 1, 0, 0,       0, 32'h0);
        step(0, 0, 32'h0,         0, 32'h14,        1, 0, 0, 0,       0, 32'h0);
        step(0, 0, 32'h0,         1, 32'h14,        1, 0, 1, 0,       0, 32'h0);
        // two redirects in DRAIN, latest wins; stall ignored in DRAIN
        step(0, 0, 32'h0,         0, 32'h200,       1, 0, 0, 0,       0, 32'h0);
        step(0, 1, 32'h300,       0, 32'h200,       1, 1, 0, 0,       0, 32'h0);
        step(0, 1, 32'h400,       0, 32'h200,       1, 1, 0, 0,       0, 32'h0);
        step(1, 0, 32'h0,         1, 32'h200,       1, 0, 1, 0,       0, 32'h0);
        // transfer with redirect in the same cycle
        step(0, 1, 32'h500,       1, 32'h400,       1, 1, 1, 0,       0, 32'h0);
        // stalled, nothing outstanding: misaligned redirect
        step(1, 1, 32'h0000_0102, 0, 32'h500,       0, 1, 0, EXP_MIS, 0, 32'h0);
        step(1, 0, 32'h0,         0, 32'h100,       0, 0, 0, 0,       0, 32'h0);
        // bit0-only misalignment is silently cleared
        step(0, 1, 32'h601,       1, 32'h100,       1, 1, 1, 0,       0, 32'h0);
        step(0, 0, 32'h0,         0, 32'h600,       1, 0, 0, 0,       0, 32'h0);
        step(0, 1, 32'h700,       0, 32'h600,       1, 1, 0, 0,       0, 32'h0);
        // ack in DRAIN together with a live redirect takes the live target
        step(0, 1, 32'h800,       1, 32'h600,       1, 1, 1, 0,       0, 32'h0);
        step(0, 1, 32'h900,       0, 32'h800,       1, 1, 0, 0,       0, 32'h0);
        step(0, 0, 32'h0,         0, 32'h800,       1, 0, 0, 0,       0, 32'h0);
        // asynchronous reset mid-DRAIN, checked before any clock edge
        i_redirect = 1'b1; i_redirect_pc = 32'hA00; i_ack = 1'b0;
        #1;
        chk("drain_flush_pre", 32'(o_flush), 32'h1);
        i_rst_n = 1'b0;
        #1;
        chk("arst_pc",    o_pc, 32'h0);
        chk("arst_req",   32'(o_req), 32'h0);
        chk("arst_flush", 32'(o_flush), 32'h0);
        chk("arst_drop",  32'(o_drop), 32'h0);
        chk("arst_wpc",   w_pc, 32'hFFFF_FFF8);
        chk("sb_empty",   32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
